// File: rtl/be_store_buf.sv
// Store byte-lane encoder plus DEPTH-entry write buffer that drains to data memory over req/ack.
// Optional misaligned-store trap is enabled by defining STORE_ALIGN_CHK_EN.
module be_store_buf #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sw,
  input  logic        sh,
  input  logic        sb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        st_stall,
  output logic        ades,
  output logic        empty,
  output logic        mem_req,
  output logic [29:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] data;
  } entry_t;

  entry_t            ent_q [DEPTH];
  entry_t            new_ent;
  entry_t            head_q, head_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              st_stall_q, st_stall_d;
  logic              empty_q, empty_d;
  logic              req_q, req_d;
  logic              ades_q, ades_d;
  logic              any_st;
  logic              misal;
  logic              push;
  logic              pop;

  // Lane encoding with sw > sh > sb priority
  always_comb begin
    new_ent      = '0;
    new_ent.addr = addr[31:2];
    if (sw) begin
      new_ent.be   = 4'b1111;
      new_ent.data = wdata;
    end else if (sh) begin
      new_ent.be   = addr[1] ? 4'b1100 : 4'b0011;
      new_ent.data = {2{wdata[15:0]}};
    end else if (sb) begin
      new_ent.be   = 4'b0001 << addr[1:0];
      new_ent.data = {4{wdata[7:0]}};
    end
  end

`ifdef STORE_ALIGN_CHK_EN
  always_comb begin
    misal = 1'b0;
    if (sw) begin
      misal = (addr[1:0] != 2'b00);
    end else if (sh) begin
      misal = addr[0];
    end
  end
`else
  assign misal = 1'b0;
`endif

  assign any_st = sw | sh | sb;
  assign push   = any_st & ~st_stall_q & ~misal;
  assign pop    = req_q & mem_ack;

  // Next pointer/count state and the head entry that will be visible next cycle
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    head_d     = '0;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    cnt_d      = cnt_q + CNT_W'(push) - CNT_W'(pop);
    st_stall_d = (cnt_d == CNT_W'(DEPTH));
    empty_d    = (cnt_d == '0);
    req_d      = ~empty_d;
    ades_d     = any_st & ~st_stall_q & misal;
    // A push landing on the new head slot bypasses storage so the entry shows next cycle
    if (!empty_d) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        head_d = new_ent;
      end else begin
        head_d = ent_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      st_stall_q <= 1'b0;
      empty_q    <= 1'b1;
      req_q      <= 1'b0;
      ades_q     <= 1'b0;
      head_q     <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      st_stall_q <= st_stall_d;
      empty_q    <= empty_d;
      req_q      <= req_d;
      ades_q     <= ades_d;
      head_q     <= head_d;
    end
  end

  // Entry storage carries no reset; validity is tracked by the count
  always_ff @(posedge clk) begin
    if (push) begin
      ent_q[wr_ptr_q] <= new_ent;
    end
  end

  assign st_stall  = st_stall_q;
  assign empty     = empty_q;
  assign mem_req   = req_q;
  assign ades      = ades_q;
  assign mem_addr  = head_q.addr;
  assign mem_be    = head_q.be;
  assign mem_wdata = head_q.data;

endmodule
